// File: rtl/imm_gen_pipe.sv
// Immediate decoder for RV32I/RV64I formats with a 2-entry valid/ready output buffer.
// Also flags illegal format selects and keeps a saturating count of them.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [2:0]          src,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     imm_ext,
    output logic                out_err,
    output logic [TAG_W-1:0]    out_tag,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int unsigned DEPTH = 2;

    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic             mem_err [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic             wptr;
    logic             rptr;
    logic [1:0]       count;

    logic             push;
    logic             pop;
    logic [31:0]      raw;
    logic             sx;
    logic             dec_err;
    logic [XLEN-1:0]  dec_imm;
    logic             unused_bits;

    assign unused_bits = ^instr[6:0];

    // Gather the immediate into 32 bits, then sign- or zero-extend to XLEN.
    always_comb begin
        raw     = '0;
        sx      = 1'b1;
        dec_err = 1'b0;
        case (src)
            3'b000: raw = {{20{instr[31]}}, instr[31:20]};
            3'b001: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: raw = {instr[31:12], 12'b0};
            3'b101: begin
                sx  = 1'b0;
                raw = (XLEN == 64) ? 32'(instr[25:20]) : 32'(instr[24:20]);
            end
            3'b110: begin
                sx  = 1'b0;
                raw = 32'(instr[19:15]);
            end
            default: begin
                sx      = 1'b0;
                dec_err = 1'b1;
            end
        endcase
        dec_imm = sx ? XLEN'($signed(raw)) : XLEN'(raw);
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    assign imm_ext = mem_imm[rptr];
    assign out_err = mem_err[rptr];
    assign out_tag = mem_tag[rptr];

    // Flush re-aligns both pointers so the next push lands at the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_err[i] <= 1'b0;
                mem_tag[i] <= '0;
            end
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            count   <= 2'd0;
            err_cnt <= '0;
        end else if (flush) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem_imm[wptr] <= dec_imm;
                mem_err[wptr] <= dec_err;
                mem_tag[wptr] <= in_tag;
                wptr          <= ~wptr;
                if (dec_err && (err_cnt != {ERRCNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + ERRCNT_W'(1);
                end
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven by a shared request stream.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] imm_ext32;
    logic [4:0]  out_tag32;
    logic [7:0]  err_cnt32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] imm_ext64;
    logic [4:0]  out_tag64;
    logic [7:0]  err_cnt64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(8)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .src(src), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .imm_ext(imm_ext32), .out_err(out_err32),
        .out_tag(out_tag32), .err_cnt(err_cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ERRCNT_W(8)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .src(src), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .imm_ext(imm_ext64), .out_err(out_err64),
        .out_tag(out_tag64), .err_cnt(err_cnt64)
    );

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
        logic [4:0]  tag;
    } exp_t;

    exp_t        cur;
    exp_t        q32[$];
    exp_t        q64[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          exp_err32 = 0;
    int          exp_err64 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Per-cycle model of occupancy, head contents and error count for the 32-bit instance.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst) begin
            check("valid32", 64'(out_valid32), 64'(q32.size() != 0));
            check("ready32", 64'(in_ready32), 64'(q32.size() < 2));
            check("errcnt32", 64'(err_cnt32), 64'(exp_err32));
            if (out_valid32 && out_ready && q32.size() != 0) begin
                e = q32.pop_front();
                check("imm32", 64'(imm_ext32), 64'(e.e32));
                check("err32", 64'(out_err32), 64'(e.err));
                check("tag32", 64'(out_tag32), 64'(e.tag));
            end
            if (flush) q32.delete();
            else if (in_valid && in_ready32) begin
                q32.push_back(cur);
                if (src == 3'b111 && exp_err32 < 255) exp_err32++;
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (!rst) begin
            check("valid64", 64'(out_valid64), 64'(q64.size() != 0));
            check("ready64", 64'(in_ready64), 64'(q64.size() < 2));
            check("errcnt64", 64'(err_cnt64), 64'(exp_err64));
            if (out_valid64 && out_ready && q64.size() != 0) begin
                e = q64.pop_front();
                check("imm64", imm_ext64, e.e64);
                check("err64", 64'(out_err64), 64'(e.err));
                check("tag64", 64'(out_tag64), 64'(e.tag));
            end
            if (flush) q64.delete();
            else if (in_valid && in_ready64) begin
                q64.push_back(cur);
                if (src == 3'b111 && exp_err64 < 255) exp_err64++;
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [4:0] t,
                        input logic [31:0] e32, input logic [63:0] e64);
        bit acc   = 1'b0;
        int guard = 0;
        instr    = i;
        src      = s;
        in_tag   = t;
        cur      = '{e32, e64, (s == 3'b111), t};
        in_valid = 1'b1;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int guard = 0;
        while ((q32.size() != 0 || q64.size() != 0) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; src = '0; in_tag = '0;
        cur = '{32'd0, 64'd0, 1'b0, 5'd0};
        #12;
        check("rst_valid", 64'(out_valid32), 64'd0);
        check("rst_ready", 64'(in_ready32), 64'd1);
        check("rst_imm32", 64'(imm_ext32), 64'd0);
        check("rst_imm64", imm_ext64, 64'd0);
        check("rst_errcnt", 64'(err_cnt32), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Every format, back to back
        send(32'hA7500000, 3'b000, 5'd1, 32'hFFFFFA75, 64'hFFFFFFFFFFFFFA75);
        check("latency", 64'(out_valid32), 64'd1);
        send(32'hA6000A80, 3'b001, 5'd2, 32'hFFFFFA75, 64'hFFFFFFFFFFFFFA75);
        send(32'hA6000A80, 3'b010, 5'd3, 32'hFFFFFA74, 64'hFFFFFFFFFFFFFA74);
        send(32'hA6000A80, 3'b011, 5'd4, 32'hFFF00260, 64'hFFFFFFFFFFF00260);
        send(32'hA6000A80, 3'b100, 5'd5, 32'hA6000000, 64'hFFFFFFFFA6000000);
        send(32'h01F00013, 3'b101, 5'd6, 32'h0000001F, 64'h000000000000001F);
        send(32'h03F00013, 3'b101, 5'd7, 32'h0000001F, 64'h000000000000003F);
        send(32'h000F8073, 3'b110, 5'd8, 32'h0000001F, 64'h000000000000001F);
        send(32'h80000000, 3'b110, 5'd9, 32'h00000000, 64'h0000000000000000);
        drain();

        // Backpressure: two entries fill the buffer, a third is refused
        out_ready = 1'b0;
        send(32'h00100000, 3'b000, 5'd3, 32'h00000001, 64'h1);
        send(32'h00200000, 3'b000, 5'd4, 32'h00000002, 64'h2);
        check("full_ready", 64'(in_ready32), 64'd0);
        instr = 32'h00300000; src = 3'b000; in_tag = 5'd5;
        cur = '{32'h3, 64'h3, 1'b0, 5'd5};
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Flush with a simultaneous illegal push
        out_ready = 1'b0;
        send(32'h7FF00000, 3'b000, 5'd10, 32'h000007FF, 64'h7FF);
        send(32'h80000000, 3'b000, 5'd11, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800);
        flush = 1'b1; in_valid = 1'b1; src = 3'b111; in_tag = 5'd12;
        cur = '{32'h0, 64'h0, 1'b1, 5'd12};
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid32), 64'd0);
        check("flush_ready", 64'(in_ready32), 64'd1);
        check("flush_errcnt", 64'(err_cnt32), 64'd0);
        out_ready = 1'b1;
        send(32'hFFF00000, 3'b000, 5'd13, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        drain();

        // Illegal selects until the counter saturates
        for (int k = 0; k < 260; k++) begin
            send($urandom, 3'b111, 5'(k), 32'h0, 64'h0);
        end
        drain();
        check("errcnt_sat32", 64'(err_cnt32), 64'd255);
        check("errcnt_sat64", 64'(err_cnt64), 64'd255);

        // Asynchronous reset with the buffer full
        out_ready = 1'b0;
        send(32'h12300000, 3'b000, 5'd20, 32'h00000123, 64'h123);
        send(32'h45600000, 3'b000, 5'd21, 32'h00000456, 64'h456);
        #2;
        rst = 1'b1;
        q32.delete(); q64.delete();
        exp_err32 = 0; exp_err64 = 0;
        #1;
        check("arst_valid", 64'(out_valid32), 64'd0);
        check("arst_ready", 64'(in_ready32), 64'd1);
        check("arst_imm", 64'(imm_ext32), 64'd0);
        check("arst_tag", 64'(out_tag32), 64'd0);
        check("arst_err", 64'(out_err32), 64'd0);
        check("arst_errcnt", 64'(err_cnt32), 64'd0);
        check("arst_valid64", 64'(out_valid64), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'hA6000A80, 3'b011, 5'd22, 32'hFFF00260, 64'hFFFFFFFFFFF00260);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
